pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Forwarding-source bus for the hazard controller.
// Each source (index 0 = youngest stage) presents a write enable, the
// destination register and the result data it would write.
//   src_RegWr  [NUM_FWD]         per-source write enable
//   src_wsel   [NUM_FWD*REG_W]   per-source destination register
//   src_data   [NUM_FWD*DATA_W]  per-source result data
// master: the pipeline stages driving results; slave: the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5
);
  logic [NUM_FWD-1:0]        src_RegWr;
  logic [NUM_FWD*REG_W-1:0]  src_wsel;
  logic [NUM_FWD*DATA_W-1:0] src_data;

  modport master (output src_RegWr, src_wsel, src_data);
  modport slave  (input  src_RegWr, src_wsel, src_data);
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, stall/flush generation,
// halt sequencing and stall/flush performance counters.
//   CLK, nRST            clock, asynchronous active-low reset
//   id_rs/id_rt          decode-stage source registers
//   ex_rs/ex_rt          execute-stage source registers
//   ex_rdat1/ex_rdat2    register-file operands of the execute instruction
//   ex_MemRd/ex_RegWr    execute instruction is a load / writes a register
//   ex_wsel              execute destination register
//   fwd_bus              forwarding sources (see pipe_hazard_ctrl_if)
//   branch_taken, ihit, dmem_req, dhit, halt_in   pipeline events
//   fwd_rdat1/fwd_rdat2  forwarded operands (combinational)
//   stall/flush          per-latch hold / bubble: bit0 fetch .. bit3 mem
//   halt                 processor halted (sticky until reset)
//   stall_cnt/flush_cnt  saturating performance counters
//
// Halt FSM
//   state  | meaning
//   RUN    | normal operation, watching halt_in
//   DRAIN  | halt seen, letting older instructions drain for HALT_DRAIN cycles
//   HALTED | halted until reset, counters frozen
module pipe_hazard_ctrl #(
  parameter int NUM_FWD    = 3,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int HALT_DRAIN = 2,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  ex_rs,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [DATA_W-1:0] ex_rdat1,
  input  logic [DATA_W-1:0] ex_rdat2,
  input  logic              ex_MemRd,
  input  logic              ex_RegWr,
  input  logic [REG_W-1:0]  ex_wsel,
  pipe_hazard_ctrl_if.slave fwd_bus,
  input  logic              branch_taken,
  input  logic              ihit,
  input  logic              dmem_req,
  input  logic              dhit,
  input  logic              halt_in,
  output logic [DATA_W-1:0] fwd_rdat1,
  output logic [DATA_W-1:0] fwd_rdat2,
  output logic [3:0]        stall,
  output logic [3:0]        flush,
  output logic              halt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int DRAIN_W = (HALT_DRAIN > 0) ? $clog2(HALT_DRAIN + 1) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

  halt_state_e        state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               lu_done_q, lu_done_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_wait;
  logic lu_hazard;
  logic br_flush;

  // Forwarding: walk from the oldest source down so the youngest match wins.
  // A match requires a nonzero register, so r0 is never forwarded.
  always_comb begin
    fwd_rdat1 = ex_rdat1;
    fwd_rdat2 = ex_rdat2;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_bus.src_RegWr[i] && (ex_rs != '0) &&
          (fwd_bus.src_wsel[i*REG_W +: REG_W] == ex_rs))
        fwd_rdat1 = fwd_bus.src_data[i*DATA_W +: DATA_W];
      if (fwd_bus.src_RegWr[i] && (ex_rt != '0) &&
          (fwd_bus.src_wsel[i*REG_W +: REG_W] == ex_rt))
        fwd_rdat2 = fwd_bus.src_data[i*DATA_W +: DATA_W];
    end
  end

  assign mem_wait  = dmem_req & ~dhit;
  // lu_done_q masks the hazard on the cycle right after it was serviced,
  // since the load has not yet left execute from this block's point of view.
  assign lu_hazard = ex_MemRd & ex_RegWr & (ex_wsel != '0) &
                     ((ex_wsel == id_rs) | (ex_wsel == id_rt)) & ~lu_done_q;

  always_comb begin
    stall     = 4'b0000;
    flush     = 4'b0000;
    br_flush  = 1'b0;
    lu_done_d = 1'b0;
    if (mem_wait) begin
      stall = 4'b1111;
      flush = 4'b0001;
    end else if (branch_taken) begin
      flush    = 4'b0111;
      br_flush = 1'b1;
    end else if (lu_hazard) begin
      stall     = 4'b0011;
      flush     = 4'b0100;
      lu_done_d = 1'b1;
    end else if (!ihit) begin
      flush = 4'b0001;
    end
    // Stop fetching new instructions once a halt is under way.
    if (state_q != RUN)
      flush[0] = 1'b1;
    // Outputs are held quiet for the whole reset, not just after the edge.
    if (!nRST) begin
      stall    = 4'b0000;
      flush    = 4'b0000;
      br_flush = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      RUN: begin
        if (halt_in) begin
          if (HALT_DRAIN == 0) begin
            state_d = HALTED;
          end else begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_W'(HALT_DRAIN);
          end
        end
      end
      DRAIN: begin
        // Leave on the decrement that reaches zero: halt asserts exactly
        // HALT_DRAIN cycles after the first DRAIN cycle.
        if (drain_cnt_q <= DRAIN_W'(1)) begin
          drain_cnt_d = '0;
          state_d     = HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d     = RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_q != HALTED) begin
      if ((|stall) && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (br_flush && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      lu_done_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      lu_done_q   <= lu_done_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Decoded from the async-reset state so it drops the moment reset asserts.
  assign halt      = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int NUM_FWD    = 3;
  localparam int DATA_W     = 32;
  localparam int REG_W      = 5;
  localparam int HALT_DRAIN = 2;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  logic [REG_W-1:0]  id_rs, id_rt, ex_rs, ex_rt, ex_wsel;
  logic [DATA_W-1:0] ex_rdat1, ex_rdat2;
  logic ex_MemRd, ex_RegWr, branch_taken, ihit, dmem_req, dhit, halt_in;
  logic [DATA_W-1:0] fwd_rdat1, fwd_rdat2;
  logic [3:0] stall, flush;
  logic halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [NUM_FWD-1:0]        src_we;
  logic [NUM_FWD*REG_W-1:0]  src_ws;
  logic [NUM_FWD*DATA_W-1:0] src_dat;

  pipe_hazard_ctrl_if #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();
  assign bus.src_RegWr = src_we;
  assign bus.src_wsel  = src_ws;
  assign bus.src_data  = src_dat;

  pipe_hazard_ctrl #(
    .NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_W(REG_W),
    .HALT_DRAIN(HALT_DRAIN), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2),
    .ex_MemRd(ex_MemRd), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
    .fwd_bus(bus),
    .branch_taken(branch_taken), .ihit(ihit), .dmem_req(dmem_req),
    .dhit(dhit), .halt_in(halt_in),
    .fwd_rdat1(fwd_rdat1), .fwd_rdat2(fwd_rdat2),
    .stall(stall), .flush(flush), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: cycle index, cycle at which halt becomes visible,
  // whether the previous cycle serviced a load-use, and counter values.
  int cyc       = 0;
  int halt_at   = -1;
  bit m_lu_done = 1'b0;
  int m_scnt    = 0;
  int m_fcnt    = 0;

  // Per-cycle results of the model, consumed when the clock edge is modelled.
  logic [3:0] e_st, e_fl;
  bit e_halted, e_br, e_lu_taken;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic we, input logic [REG_W-1:0] ws,
                         input logic [DATA_W-1:0] d);
    src_we[i] = we;
    src_ws[i*REG_W +: REG_W] = ws;
    src_dat[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_wsel = '0;
    ex_rdat1 = 32'h0; ex_rdat2 = 32'h0;
    ex_MemRd = 1'b0; ex_RegWr = 1'b0;
    branch_taken = 1'b0; ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b1; halt_in = 1'b0;
    src_we = '0; src_ws = '0; src_dat = '0;
  endtask

  function automatic logic [DATA_W-1:0] fwd_model(input logic [REG_W-1:0] r,
                                                  input logic [DATA_W-1:0] dflt);
    if (r == '0) return dflt;
    for (int i = 0; i < NUM_FWD; i++)
      if (src_we[i] && src_ws[i*REG_W +: REG_W] == r) return src_dat[i*DATA_W +: DATA_W];
    return dflt;
  endfunction

  // Compare all outputs at the falling edge against the model.
  task automatic sample(input string tag);
    bit halted, draining, mw, lu;
    @(negedge CLK);
    halted   = (halt_at >= 0) && (cyc >= halt_at);
    draining = (halt_at >= 0) && !halted;
    mw = dmem_req && !dhit;
    lu = ex_MemRd && ex_RegWr && (ex_wsel != 0) &&
         ((ex_wsel == id_rs) || (ex_wsel == id_rt)) && !m_lu_done;
    e_st = 4'h0; e_fl = 4'h0; e_br = 1'b0; e_lu_taken = 1'b0;
    if (mw) begin
      e_st = 4'hF; e_fl = 4'h1;
    end else if (branch_taken) begin
      e_fl = 4'h7; e_br = 1'b1;
    end else if (lu) begin
      e_st = 4'h3; e_fl = 4'h4; e_lu_taken = 1'b1;
    end else if (!ihit) begin
      e_fl = 4'h1;
    end
    if (draining || halted) e_fl[0] = 1'b1;
    e_halted = halted;
    chk({tag, ".fwd1"},  fwd_rdat1, fwd_model(ex_rs, ex_rdat1));
    chk({tag, ".fwd2"},  fwd_rdat2, fwd_model(ex_rt, ex_rdat2));
    chk({tag, ".stall"}, stall, e_st);
    chk({tag, ".flush"}, flush, e_fl);
    chk({tag, ".halt"},  halt, halted);
    chk({tag, ".scnt"},  stall_cnt, m_scnt);
    chk({tag, ".fcnt"},  flush_cnt, m_fcnt);
  endtask

  // Apply the effect of the coming rising edge to the model, then step.
  task automatic advance();
    if (!e_halted) begin
      if (e_st != 4'h0 && m_scnt < CNT_MAX) m_scnt++;
      if (e_br && m_fcnt < CNT_MAX) m_fcnt++;
    end
    m_lu_done = e_lu_taken;
    if (halt_at < 0 && halt_in) halt_at = cyc + 1 + HALT_DRAIN;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    nRST = 1'b0;
    @(negedge CLK);
    chk("rst.stall", stall, 0);
    chk("rst.flush", flush, 0);
    chk("rst.halt",  halt, 0);
    chk("rst.scnt",  stall_cnt, 0);
    chk("rst.fcnt",  flush_cnt, 0);
    halt_at = -1; m_lu_done = 1'b0; m_scnt = 0; m_fcnt = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cyc++;
  endtask

  initial begin
    idle();
    // Reset with busy inputs: stall/flush must still read zero.
    dmem_req = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
    reset_dut();
    idle();

    // Forwarding: youngest source wins.
    ex_rs = 5'd5; ex_rdat1 = 32'h1111;
    set_src(0, 1'b1, 5'd5, 32'hAAAA);
    set_src(2, 1'b1, 5'd5, 32'hBBBB);
    sample("fwd_near");
    chk("fwd_near.const", fwd_rdat1, 32'hAAAA);
    advance();
    // Register 0 is never forwarded.
    ex_rs = 5'd0; ex_rdat1 = 32'h1234;
    set_src(0, 1'b1, 5'd0, 32'hCCCC);
    sample("fwd_r0");
    chk("fwd_r0.const", fwd_rdat1, 32'h1234);
    advance();
    // Operand 2 from the oldest source only.
    idle();
    ex_rt = 5'd7; ex_rdat2 = 32'h2222;
    set_src(2, 1'b1, 5'd7, 32'hDDDD);
    sample("fwd_rt");
    chk("fwd_rt.const", fwd_rdat2, 32'hDDDD);
    advance();

    // Load-use: one stall cycle, then suppressed, operand from src0.
    idle();
    ex_MemRd = 1'b1; ex_RegWr = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3;
    sample("lu1");
    chk("lu1.stall", stall, 4'b0011);
    chk("lu1.flush", flush, 4'b0100);
    advance();
    ex_rs = 5'd3; ex_rdat1 = 32'h0;
    set_src(0, 1'b1, 5'd3, 32'h5555);
    sample("lu2");
    chk("lu2.stall", stall, 4'b0000);
    chk("lu2.flush", flush, 4'b0000);
    chk("lu2.fwd",   fwd_rdat1, 32'h5555);
    chk("lu2.scnt",  stall_cnt, 1);
    advance();
    idle();

    // Data miss for 3 cycles with a branch in cycle 2.
    reset_dut();
    idle();
    dmem_req = 1'b1; dhit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      branch_taken = (k == 1);
      sample("miss");
      chk("miss.stall", stall, 4'b1111);
      chk("miss.flush", flush, 4'b0001);
      advance();
    end
    idle();
    sample("miss_done");
    chk("miss_done.scnt", stall_cnt, 3);
    chk("miss_done.fcnt", flush_cnt, 0);
    advance();

    // Branch beats a simultaneous load-use.
    ex_MemRd = 1'b1; ex_RegWr = 1'b1; ex_wsel = 5'd4; id_rt = 5'd4;
    branch_taken = 1'b1;
    sample("br_lu");
    chk("br_lu.flush", flush, 4'b0111);
    chk("br_lu.stall", stall, 4'b0000);
    advance();
    idle();
    sample("br_done");
    chk("br_done.fcnt", flush_cnt, 1);
    advance();

    // Halt sequencing and asynchronous exit.
    reset_dut();
    idle();
    halt_in = 1'b1;
    sample("halt_t0");
    advance();
    halt_in = 1'b0;
    sample("halt_t1");
    chk("halt_t1.halt", halt, 0);
    chk("halt_t1.flush0", flush[0], 1);
    advance();
    sample("halt_t2");
    chk("halt_t2.halt", halt, 0);
    advance();
    dmem_req = 1'b1; dhit = 1'b0; halt_in = 1'b1;
    sample("halt_t3");
    chk("halt_t3.halt", halt, 1);
    advance();
    sample("halt_t4");
    chk("halt_t4.halt", halt, 1);
    chk("halt_t4.scnt", stall_cnt, 0);
    advance();
    nRST = 1'b0;
    #1;
    chk("halt_t5.async", halt, 0);
    reset_dut();
    idle();

    // Saturation after 20 stall cycles.
    dmem_req = 1'b1; dhit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample("sat");
      advance();
    end
    idle();
    sample("sat_done");
    chk("sat_done.scnt", stall_cnt, CNT_MAX);
    advance();

    // Randomized traffic against the model.
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) reset_dut();
      id_rs    = 5'($urandom_range(0, 3));
      id_rt    = 5'($urandom_range(0, 3));
      ex_rs    = 5'($urandom_range(0, 3));
      ex_rt    = 5'($urandom_range(0, 3));
      ex_wsel  = 5'($urandom_range(0, 3));
      ex_rdat1 = $urandom;
      ex_rdat2 = $urandom;
      ex_MemRd = 1'($urandom_range(0, 1));
      ex_RegWr = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 4) == 0);
      ihit     = ($urandom_range(0, 3) != 0);
      dmem_req = 1'($urandom_range(0, 1));
      dhit     = ($urandom_range(0, 2) != 0);
      halt_in  = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_FWD; i++)
        set_src(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      sample("rnd");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
